move_input_ctrl: RTL

- Input-conditioning stage directly upstream of the CatTrap game core.
- Synchronises and debounces BtnC/BtnD and synchronises the one-hot Row/Col switch banks.
- Validates the switch selection and encodes it to binary cell indices.
- Hands each move to the game core over a valid/ready handshake, one move per BtnD press. A BtnC press produces a one-cycle new_game pulse.

---
 rtl/cattrap_pkg.sv | 29 ++
 rtl/btn_debounce.sv | 57 +++++
 rtl/move_input_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cattrap_pkg.sv
// Shared types and helpers for the CatTrap input path: grid sizing, move FSM states and
// one-hot selection decoding.
package cattrap_pkg;

  localparam int unsigned GRID_N = 8;
  localparam int unsigned IDX_W  = $clog2(GRID_N);

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StOffer,
    StWaitRelease
  } move_state_e;

  function automatic logic is_onehot(input logic [GRID_N-1:0] v);
    return $onehot(v);
  endfunction

  // Only meaningful when is_onehot(v) holds.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [GRID_N-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < GRID_N; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises one raw button, debounces it into a stable level and emits a one-cycle
// pulse on each accepted press.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   press_q, press_d;
  logic                   btn_s;

  assign btn_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (btn_s == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = btn_s;
      cnt_d    = '0;
      press_d  = btn_s;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_q[0] <= btn_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign level_o = stable_q;
  assign press_o = press_q;

endmodule

// File: rtl/move_input_ctrl.sv
// Conditions BtnC/BtnD and the Row/Col switch banks and offers one validated move per
// BtnD press to the game core over a valid/ready handshake.
module move_input_ctrl
  import cattrap_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              BtnC,
  input  logic              BtnD,
  input  logic [GRID_N-1:0] Row,
  input  logic [GRID_N-1:0] Col,
  output logic              move_valid,
  input  logic              move_ready,
  output logic [IDX_W-1:0]  move_row,
  output logic [IDX_W-1:0]  move_col,
  output logic              sel_error,
  output logic              new_game
);

  logic c_level, c_press, d_level, d_press;
  logic unused_c_level;

  assign unused_c_level = c_level;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_btn_c (
    .clk_i  (clk),
    .rst_ni (Reset_n),
    .btn_i  (BtnC),
    .level_o(c_level),
    .press_o(c_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_btn_d (
    .clk_i  (clk),
    .rst_ni (Reset_n),
    .btn_i  (BtnD),
    .level_o(d_level),
    .press_o(d_press)
  );

  logic [GRID_N-1:0] row_sync_q [SYNC_STAGES];
  logic [GRID_N-1:0] col_sync_q [SYNC_STAGES];
  logic [GRID_N-1:0] row_lat_q, row_lat_d, col_lat_q, col_lat_d;
  logic [IDX_W-1:0]  move_row_q, move_row_d, move_col_q, move_col_d;
  logic              move_valid_q, move_valid_d;
  logic              sel_error_q, sel_error_d;
  logic              new_game_q, new_game_d;
  move_state_e       state_q, state_d;

  always_comb begin
    state_d      = state_q;
    row_lat_d    = row_lat_q;
    col_lat_d    = col_lat_q;
    move_row_d   = move_row_q;
    move_col_d   = move_col_q;
    move_valid_d = move_valid_q;
    sel_error_d  = sel_error_q;
    new_game_d   = 1'b0;
    // BtnC overrides everything, including a BtnD press in the same cycle.
    if (c_press) begin
      new_game_d   = 1'b1;
      state_d      = StWaitRelease;
      move_valid_d = 1'b0;
      sel_error_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (d_press) begin
            row_lat_d = row_sync_q[SYNC_STAGES-1];
            col_lat_d = col_sync_q[SYNC_STAGES-1];
            state_d   = StCheck;
          end
        end
        StCheck: begin
          if (is_onehot(row_lat_q) && is_onehot(col_lat_q)) begin
            move_row_d   = onehot_to_idx(row_lat_q);
            move_col_d   = onehot_to_idx(col_lat_q);
            sel_error_d  = 1'b0;
            move_valid_d = 1'b1;
            state_d      = StOffer;
          end else begin
            sel_error_d = 1'b1;
            state_d     = StWaitRelease;
          end
        end
        StOffer: begin
          if (move_ready) begin
            move_valid_d = 1'b0;
            state_d      = StWaitRelease;
          end
        end
        StWaitRelease: begin
          if (!d_level) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        row_sync_q[i] <= '0;
        col_sync_q[i] <= '0;
      end
      state_q      <= StIdle;
      row_lat_q    <= '0;
      col_lat_q    <= '0;
      move_row_q   <= '0;
      move_col_q   <= '0;
      move_valid_q <= 1'b0;
      sel_error_q  <= 1'b0;
      new_game_q   <= 1'b0;
    end else begin
      row_sync_q[0] <= Row;
      col_sync_q[0] <= Col;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        row_sync_q[i] <= row_sync_q[i-1];
        col_sync_q[i] <= col_sync_q[i-1];
      end
      state_q      <= state_d;
      row_lat_q    <= row_lat_d;
      col_lat_q    <= col_lat_d;
      move_row_q   <= move_row_d;
      move_col_q   <= move_col_d;
      move_valid_q <= move_valid_d;
      sel_error_q  <= sel_error_d;
      new_game_q   <= new_game_d;
    end
  end

  assign move_valid = move_valid_q;
  assign move_row   = move_row_q;
  assign move_col   = move_col_q;
  assign sel_error  = sel_error_q;
  assign new_game   = new_game_q;

endmodule
